// File: rtl/wb_line_fetcher_pkg.sv
// -----------------------------------------------------------------------------
// wb_fetch_pkg
//   Shared definitions for the Wishbone line fetcher.
//   - fetch_state_t : fetch FSM encoding (IDLE, REQ, GAP, DONE)
//   - clog2_words() : counter width for a word count, never less than one bit
// -----------------------------------------------------------------------------
package wb_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

    // A one-word line still needs a one-bit counter to index it.
    function automatic int clog2_words(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_line_fetcher_if.sv
// -----------------------------------------------------------------------------
// wb_line_fetcher_if
//   Classic Wishbone read-side bus between the line fetcher and the
//   instruction memory.
//   Ports (signals):
//     wb_cyc_o   master->slave  bus cycle
//     wb_stb_o   master->slave  strobe
//     wb_we_o    master->slave  write enable (always 0 from the fetcher)
//     wb_sel_o   master->slave  byte selects (always all-ones)
//     wb_addr_o  master->slave  byte address of the current word
//     wb_data_i  slave->master  read data
//     wb_ack_i   slave->master  transfer acknowledge
//     wb_err_i   slave->master  transfer error
//   Modports: master (fetcher side), slave (memory side).
// -----------------------------------------------------------------------------
interface wb_line_fetcher_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [DATA_W/8-1:0]   wb_sel_o;
    logic [ADDR_W-1:0]     wb_addr_o;
    logic [DATA_W-1:0]     wb_data_i;
    logic                  wb_ack_i;
    logic                  wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o,
        input  wb_data_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o,
        output wb_data_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_line_fetcher.sv
// -----------------------------------------------------------------------------
// wb_line_fetcher
//   Builds a LINE_WORDS x DATA_W instruction line out of single-word Wishbone
//   reads, with optional back-to-back (burst) strobing, line alignment, and
//   bus-error / ack-timeout reporting.
//   Ports:
//     clk_core  in   clock
//     rst_core  in   asynchronous active-high reset
//     req_i     in   line request, only looked at while idle
//     addr_i    in   line byte address, captured with req_i
//     rdata_o   out  assembled line, word k at [k*DATA_W +: DATA_W]
//     resp_o    out  one-cycle pulse when the line is complete or aborted
//     err_o     out  qualifies resp_o: a bus error or timeout occurred
//     busy_o    out  high whenever a fetch is in progress
//     wb        master modport of wb_line_fetcher_if
// -----------------------------------------------------------------------------
module wb_line_fetcher
    import wb_fetch_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINE_WORDS     = 4,
    parameter int BURST          = 0,
    parameter int ALIGN_LINE     = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                         clk_core,
    input  logic                         rst_core,
    input  logic                         req_i,
    input  logic [ADDR_W-1:0]            addr_i,
    output logic [LINE_WORDS*DATA_W-1:0] rdata_o,
    output logic                         resp_o,
    output logic                         err_o,
    output logic                         busy_o,
    wb_line_fetcher_if.master            wb
);

    localparam int BYTES_W    = DATA_W / 8;
    localparam int LINE_BYTES = LINE_WORDS * BYTES_W;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int WC_W       = clog2_words(LINE_WORDS);
    localparam int TMO_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BYTES_W);
    localparam logic [WC_W-1:0]   LAST_WORD  = WC_W'(LINE_WORDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   =
        TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_GAP  = GAP;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]                         state;
    logic                               cyc_q;
    logic                               stb_q;
    logic [ADDR_W-1:0]                  addr_q;
    logic [WC_W-1:0]                    word_cnt;
    logic [TMO_W-1:0]                   tmo_cnt;
    logic                               err_flag;
    logic [LINE_WORDS-1:0][DATA_W-1:0]  line_q;

    logic [ADDR_W-1:0]                  cap_addr;
    logic                               tmo_hit;

    assign cap_addr = (ALIGN_LINE != 0) ? (addr_i & ALIGN_MASK) : addr_i;
    // tmo_cnt counts REQ cycles for the current word; it is cleared on every ack.
    assign tmo_hit  = (TIMEOUT_CYCLES > 0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state    <= S_IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            addr_q   <= '0;
            word_cnt <= '0;
            tmo_cnt  <= '0;
            err_flag <= 1'b0;
            line_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        addr_q   <= cap_addr;
                        word_cnt <= '0;
                        tmo_cnt  <= '0;
                        cyc_q    <= 1'b1;
                        stb_q    <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // Error (bus or timeout) takes priority over a same-cycle ack
                    // and abandons the rest of the line.
                    if (wb.wb_err_i || tmo_hit) begin
                        cyc_q    <= 1'b0;
                        stb_q    <= 1'b0;
                        err_flag <= 1'b1;
                        state    <= S_DONE;
                    end else if (wb.wb_ack_i) begin
                        line_q[word_cnt] <= wb.wb_data_i;
                        tmo_cnt          <= '0;
                        if (word_cnt == LAST_WORD) begin
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            addr_q   <= addr_q + ADDR_STEP;
                            word_cnt <= word_cnt + 1'b1;
                            if (BURST == 0) begin
                                stb_q <= 1'b0;
                                state <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    stb_q <= 1'b1;
                    state <= S_REQ;
                end
                S_DONE: begin
                    err_flag <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata_o      = line_q;
    assign resp_o       = (state == S_DONE);
    assign err_o        = (state == S_DONE) && err_flag;
    assign busy_o       = (state != S_IDLE);

    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_stb_o  = stb_q;
    assign wb.wb_we_o   = 1'b0;
    assign wb.wb_sel_o  = '1;
    assign wb.wb_addr_o = addr_q;

endmodule

// File: tb/tb_wb_line_fetcher.sv
// -----------------------------------------------------------------------------
// tb_wb_line_fetcher
//   Three fetcher instances sharing one clock:
//     dut0: defaults (BURST=0, ALIGN_LINE=1, no timeout)
//     dut1: BURST=1, ALIGN_LINE=1, TIMEOUT_CYCLES=8
//     dut2: BURST=0, ALIGN_LINE=0, no timeout
//   Each has a combinational Wishbone slave whose data is salt + addr[9:2],
//   with programmable ack delay and error injection by word position.
// -----------------------------------------------------------------------------
module tb_wb_line_fetcher;

    typedef struct packed {
        logic [127:0] line;
        logic         err;
    } resp_t;

    typedef struct {
        int          dut;
        logic [31:0] addr;
        logic [31:0] salt;
        bit          ack_en;
        bit          err_en;
        logic [1:0]  err_word;
        int          dly;
        bit          poke;
        int          lat;
        bit          exp_err;
    } vec_t;

    logic clk_core = 1'b0;
    logic rst_core;
    always #5 clk_core = ~clk_core;

    logic         req_r   [3];
    logic [31:0]  addr_r  [3];
    logic [127:0] rdata_w [3];
    logic         resp_w  [3];
    logic         err_w   [3];
    logic         busy_w  [3];
    logic         cyc_w   [3];
    logic         stb_w   [3];
    logic         we_w    [3];
    logic [3:0]   sel_w   [3];
    logic [31:0]  wadr_w  [3];
    logic         ack_w   [3];
    logic         berr_w  [3];
    logic [31:0]  dat_w   [3];

    bit           ack_en   [3];
    bit           err_en   [3];
    logic [1:0]   err_word [3];
    logic [31:0]  salt     [3];
    int           ack_dly  [3];

    bit           burst_p [3];
    bit           align_p [3];
    logic         ackp    [3];

    logic [127:0] mline    [3];
    logic [31:0]  exp_addr [3][$];
    resp_t        exp_resp [3][$];

    int nchk = 0;
    int nerr = 0;

    wb_line_fetcher_if #(.ADDR_W(32), .DATA_W(32)) wb0 ();
    wb_line_fetcher_if #(.ADDR_W(32), .DATA_W(32)) wb1 ();
    wb_line_fetcher_if #(.ADDR_W(32), .DATA_W(32)) wb2 ();

    wb_line_fetcher #(.BURST(0), .ALIGN_LINE(1), .TIMEOUT_CYCLES(0)) dut0 (
        .clk_core(clk_core), .rst_core(rst_core), .req_i(req_r[0]), .addr_i(addr_r[0]),
        .rdata_o(rdata_w[0]), .resp_o(resp_w[0]), .err_o(err_w[0]), .busy_o(busy_w[0]),
        .wb(wb0)
    );
    wb_line_fetcher #(.BURST(1), .ALIGN_LINE(1), .TIMEOUT_CYCLES(8)) dut1 (
        .clk_core(clk_core), .rst_core(rst_core), .req_i(req_r[1]), .addr_i(addr_r[1]),
        .rdata_o(rdata_w[1]), .resp_o(resp_w[1]), .err_o(err_w[1]), .busy_o(busy_w[1]),
        .wb(wb1)
    );
    wb_line_fetcher #(.BURST(0), .ALIGN_LINE(0), .TIMEOUT_CYCLES(0)) dut2 (
        .clk_core(clk_core), .rst_core(rst_core), .req_i(req_r[2]), .addr_i(addr_r[2]),
        .rdata_o(rdata_w[2]), .resp_o(resp_w[2]), .err_o(err_w[2]), .busy_o(busy_w[2]),
        .wb(wb2)
    );

    assign cyc_w[0]  = wb0.wb_cyc_o;
    assign stb_w[0]  = wb0.wb_stb_o;
    assign we_w[0]   = wb0.wb_we_o;
    assign sel_w[0]  = wb0.wb_sel_o;
    assign wadr_w[0] = wb0.wb_addr_o;
    assign wb0.wb_ack_i  = ack_w[0];
    assign wb0.wb_err_i  = berr_w[0];
    assign wb0.wb_data_i = dat_w[0];

    assign cyc_w[1]  = wb1.wb_cyc_o;
    assign stb_w[1]  = wb1.wb_stb_o;
    assign we_w[1]   = wb1.wb_we_o;
    assign sel_w[1]  = wb1.wb_sel_o;
    assign wadr_w[1] = wb1.wb_addr_o;
    assign wb1.wb_ack_i  = ack_w[1];
    assign wb1.wb_err_i  = berr_w[1];
    assign wb1.wb_data_i = dat_w[1];

    assign cyc_w[2]  = wb2.wb_cyc_o;
    assign stb_w[2]  = wb2.wb_stb_o;
    assign we_w[2]   = wb2.wb_we_o;
    assign sel_w[2]  = wb2.wb_sel_o;
    assign wadr_w[2] = wb2.wb_addr_o;
    assign wb2.wb_ack_i  = ack_w[2];
    assign wb2.wb_err_i  = berr_w[2];
    assign wb2.wb_data_i = dat_w[2];

    for (genvar g = 0; g < 3; g++) begin : g_slv
        int stall = 0;
        assign ack_w[g]  = cyc_w[g] & stb_w[g] & ack_en[g] & (stall >= ack_dly[g]);
        assign berr_w[g] = cyc_w[g] & stb_w[g] & err_en[g] & (wadr_w[g][3:2] == err_word[g]);
        assign dat_w[g]  = salt[g] + {24'd0, wadr_w[g][9:2]};
        always @(posedge clk_core)
            stall <= (cyc_w[g] && stb_w[g] && !ack_w[g] && !berr_w[g]) ? stall + 1 : 0;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: transfer addresses, the stb behaviour right after an ack,
    // and the line/err returned with each resp pulse.
    always @(negedge clk_core) begin
        logic [31:0] a;
        resp_t       r;
        for (int i = 0; i < 3; i++) begin
            if (cyc_w[i] && stb_w[i] && (ack_w[i] || berr_w[i])) begin
                nchk++;
                if (exp_addr[i].size() == 0) begin
                    nerr++;
                    $display("FAIL addr_unexpected dut%0d: got %0h, want no transfer", i, wadr_w[i]);
                end else begin
                    nchk--;
                    a = exp_addr[i].pop_front();
                    check($sformatf("addr dut%0d", i), 128'(wadr_w[i]), 128'(a));
                end
            end
            if (ackp[i])
                check($sformatf("stb_after_ack dut%0d", i), 128'(stb_w[i]),
                      128'(burst_p[i] ? cyc_w[i] : 1'b0));
            ackp[i] <= cyc_w[i] && stb_w[i] && ack_w[i] && !berr_w[i];
            if (resp_w[i]) begin
                nchk++;
                if (exp_resp[i].size() == 0) begin
                    nerr++;
                    $display("FAIL resp_unexpected dut%0d: got resp=1, want none", i);
                end else begin
                    nchk--;
                    r = exp_resp[i].pop_front();
                    check($sformatf("rdata dut%0d", i), rdata_w[i], r.line);
                    check($sformatf("err dut%0d", i), 128'(err_w[i]), 128'(r.err));
                end
            end
        end
    end

    // Model of one line fetch: expected addresses and the resulting line.
    task automatic expect_line(input int i, input logic [31:0] a, input bit exp_err);
        logic [31:0] base, wa;
        resp_t       r;
        bit          stop;
        base   = align_p[i] ? (a & 32'hFFFF_FFF0) : a;
        r.line = mline[i];
        r.err  = exp_err;
        stop   = 1'b0;
        if (ack_en[i]) begin
            for (int k = 0; k < 4; k++) begin
                if (!stop) begin
                    wa = base + 32'(4 * k);
                    exp_addr[i].push_back(wa);
                    if (err_en[i] && wa[3:2] == err_word[i]) stop = 1'b1;
                    else r.line[k*32 +: 32] = salt[i] + {24'd0, wa[9:2]};
                end
            end
        end
        mline[i] = r.line;
        exp_resp[i].push_back(r);
    endtask

    task automatic run_vec(input int i, input logic [31:0] a, input bit exp_err,
                           input int exp_lat, input bit poke);
        int lat;
        expect_line(i, a, exp_err);
        @(negedge clk_core);
        req_r[i]  = 1'b1;
        addr_r[i] = a;
        @(negedge clk_core);
        req_r[i]  = 1'b0;
        lat = 1;
        while (!resp_w[i] && lat < 100) begin
            if (poke && lat == 3) begin
                req_r[i]  = 1'b1;
                addr_r[i] = 32'hDEAD_0000;
            end else begin
                req_r[i] = 1'b0;
            end
            @(negedge clk_core);
            lat++;
        end
        req_r[i] = 1'b0;
        check($sformatf("latency dut%0d addr %0h", i, a), 128'(lat), 128'(exp_lat));
        @(negedge clk_core);
        check($sformatf("busy_after dut%0d", i), 128'(busy_w[i]), 128'(0));
        check($sformatf("resp_pulse dut%0d", i), 128'(resp_w[i]), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t vt [10];
        int   n, rises, resps;
        logic prev_busy;

        //      dut  addr           salt           ack err ew dly poke lat err
        vt[0] = '{0, 32'h0000_1000, 32'h0000_00A0, 1, 0, 0, 0, 0,  8, 0};
        vt[1] = '{0, 32'h0000_2034, 32'h1111_0000, 1, 0, 0, 2, 1, 16, 0};
        vt[2] = '{0, 32'h0000_3000, 32'h2222_0000, 1, 1, 2, 0, 0,  6, 1};
        vt[3] = '{0, 32'h0000_4000, 32'h3333_0000, 1, 1, 0, 0, 0,  2, 1};
        vt[4] = '{1, 32'h0000_1008, 32'h4444_0000, 1, 0, 0, 0, 0,  5, 0};
        vt[5] = '{1, 32'h0000_1000, 32'h0000_0000, 0, 0, 0, 0, 0,  9, 1};
        vt[6] = '{1, 32'h0000_2000, 32'h5555_0000, 1, 0, 0, 6, 1, 29, 0};
        vt[7] = '{1, 32'h0000_3000, 32'h6666_0000, 1, 1, 3, 0, 0,  5, 1};
        vt[8] = '{2, 32'hFFFF_FFF8, 32'h7777_0000, 1, 0, 0, 0, 0,  8, 0};
        vt[9] = '{2, 32'h0000_0106, 32'h8888_0000, 1, 0, 0, 1, 1, 12, 0};

        burst_p = '{1'b0, 1'b1, 1'b0};
        align_p = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            req_r[i]    = 1'b0;
            addr_r[i]   = '0;
            ack_en[i]   = 1'b1;
            err_en[i]   = 1'b0;
            err_word[i] = '0;
            salt[i]     = '0;
            ack_dly[i]  = 0;
            mline[i]    = '0;
            ackp[i]     = 1'b0;
        end

        rst_core = 1'b1;
        repeat (3) @(negedge clk_core);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_cyc dut%0d", i),   128'(cyc_w[i]),  128'(0));
            check($sformatf("rst_stb dut%0d", i),   128'(stb_w[i]),  128'(0));
            check($sformatf("rst_busy dut%0d", i),  128'(busy_w[i]), 128'(0));
            check($sformatf("rst_resp dut%0d", i),  128'(resp_w[i]), 128'(0));
            check($sformatf("rst_err dut%0d", i),   128'(err_w[i]),  128'(0));
            check($sformatf("rst_addr dut%0d", i),  128'(wadr_w[i]), 128'(0));
            check($sformatf("rst_rdata dut%0d", i), rdata_w[i],      128'(0));
            check($sformatf("we dut%0d", i),        128'(we_w[i]),   128'(0));
            check($sformatf("sel dut%0d", i),       128'(sel_w[i]),  128'(4'hF));
        end
        rst_core = 1'b0;
        @(negedge clk_core);

        for (int v = 0; v < 10; v++) begin
            ack_en[vt[v].dut]   = vt[v].ack_en;
            err_en[vt[v].dut]   = vt[v].err_en;
            err_word[vt[v].dut] = vt[v].err_word;
            ack_dly[vt[v].dut]  = vt[v].dly;
            salt[vt[v].dut]     = vt[v].salt;
            run_vec(vt[v].dut, vt[v].addr, vt[v].exp_err, vt[v].lat, vt[v].poke);
            if (v == 0)
                check("line_t1", rdata_w[0], 128'h000000A3_000000A2_000000A1_000000A0);
        end

        // Reset in the middle of a line: word 2 is being strobed, not yet acked.
        ack_en[0]  = 1'b1;
        err_en[0]  = 1'b0;
        ack_dly[0] = 3;
        salt[0]    = 32'h9999_0000;
        exp_addr[0].push_back(32'h0000_5000);
        exp_addr[0].push_back(32'h0000_5004);
        @(negedge clk_core);
        req_r[0]  = 1'b1;
        addr_r[0] = 32'h0000_5000;
        @(negedge clk_core);
        req_r[0]  = 1'b0;
        n = 0;
        while (!(cyc_w[0] && stb_w[0] && wadr_w[0] == 32'h0000_5008) && n < 100) begin
            @(negedge clk_core);
            n++;
        end
        check("t6_reach_word2", 128'(n < 100), 128'(1));
        #2;
        rst_core = 1'b1;
        #1;
        check("t6_cyc",   128'(cyc_w[0]),  128'(0));
        check("t6_stb",   128'(stb_w[0]),  128'(0));
        check("t6_busy",  128'(busy_w[0]), 128'(0));
        check("t6_resp",  128'(resp_w[0]), 128'(0));
        check("t6_rdata", rdata_w[0],      128'(0));
        for (int i = 0; i < 3; i++) mline[i] = '0;
        @(negedge clk_core);
        rst_core = 1'b0;
        ack_dly[0] = 0;
        run_vec(0, 32'h0000_5004, 1'b0, 8, 1'b0);

        // req_i held through DONE: the following IDLE cycle starts exactly one more line.
        salt[0] = 32'hABCD_0000;
        expect_line(0, 32'h0000_6000, 1'b0);
        expect_line(0, 32'h0000_6000, 1'b0);
        rises = 0;
        resps = 0;
        prev_busy = busy_w[0];
        @(negedge clk_core);
        req_r[0]  = 1'b1;
        addr_r[0] = 32'h0000_6000;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_core);
            if (busy_w[0] && !prev_busy) rises++;
            if (resp_w[0]) resps++;
            prev_busy = busy_w[0];
            if (c == 9)  check("held_idle_gap", 128'(busy_w[0]), 128'(0));
            if (c == 10) begin
                check("held_restart", 128'(busy_w[0]), 128'(1));
                req_r[0] = 1'b0;
            end
        end
        check("held_lines", 128'(rises), 128'(2));
        check("held_resps", 128'(resps), 128'(2));

        for (int i = 0; i < 3; i++) begin
            check($sformatf("addr_left dut%0d", i), 128'(exp_addr[i].size()), 128'(0));
            check($sformatf("resp_left dut%0d", i), 128'(exp_resp[i].size()), 128'(0));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
